// File: rtl/smb_pkg.sv
// Shared definitions for the SMB serial lane protocol, used by both the
// transmitter and the receiver/broadcaster.
package smb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADDR,
        DATA,
        STOP,
        DONE
    } smb_tx_state_t;

    localparam logic SMB_START_BIT  = 1'b0;
    localparam logic SMB_STOP_BIT   = 1'b1;
    localparam int   SMB_ADDR_BITS  = 2;
    localparam int   SMB_FRAME_BITS = 8;
    localparam int   SMB_LANES      = 4;

endpackage

// File: rtl/smb_serial_tx_if.sv
// Parallel request side and serial line of the SMB transmitter.
interface smb_serial_tx_if
    import smb_pkg::*;
#(
    parameter int WIDTH = 4
) ();

    logic                 valid;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic                 serout;
    logic [SMB_LANES-1:0] PB;
    logic [0:WIDTH-1]     PL0;
    logic [0:WIDTH-1]     PL1;
    logic [0:WIDTH-1]     PL2;
    logic [0:WIDTH-1]     PL3;

    modport master (
        output valid, PB, PL0, PL1, PL2, PL3,
        input  ready, busy, done, serout
    );

    modport slave (
        input  valid, PB, PL0, PL1, PL2, PL3,
        output ready, busy, done, serout
    );

endinterface

// File: rtl/smb_bit_timer.sv
// Bit-period divider: tick is high on the last cycle of each BIT_CYCLES-long bit.
module smb_bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == 8'(BIT_CYCLES - 1));
        cnt_d = (restart || tick) ? 8'd0 : cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/smb_serial_tx.sv
// SMB serial transmitter: captures four lane words plus a mask, then sends one
// 8-bit frame (start, lane index, data, stop) per selected lane, lowest lane first.
module smb_serial_tx
    import smb_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int BIT_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst,
    smb_serial_tx_if.slave  bus
);

    smb_tx_state_t        state_q, state_d;
    logic [SMB_LANES-1:0] mask_q, mask_d;
    logic [SMB_LANES-1:0] remaining;
    logic [1:0]           lane_q, lane_d;
    logic [1:0]           bit_cnt_q, bit_cnt_d;
    logic [0:WIDTH-1]     data_q [SMB_LANES];
    logic [0:WIDTH-1]     data_d [SMB_LANES];
    logic                 serout_q, serout_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick;
    logic                 timer_restart;

    function automatic logic [1:0] lowest_lane(input logic [SMB_LANES-1:0] m);
        lowest_lane = 2'd0;
        for (int i = SMB_LANES - 1; i >= 0; i--) begin
            if (m[i]) lowest_lane = 2'(i);
        end
    endfunction

    // Holding the timer cleared in IDLE makes the first bit start a full period on acceptance.
    assign timer_restart = (state_q == IDLE) || tick;

    smb_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .restart(timer_restart),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        lane_d    = lane_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        remaining = mask_q & ~(SMB_LANES'(1) << lane_q);

        case (state_q)
            IDLE: begin
                if (bus.valid) begin
                    mask_d    = bus.PB;
                    data_d[0] = bus.PL0;
                    data_d[1] = bus.PL1;
                    data_d[2] = bus.PL2;
                    data_d[3] = bus.PL3;
                    bit_cnt_d = 2'd0;
                    if (bus.PB != '0) begin
                        state_d = START;
                        lane_d  = lowest_lane(bus.PB);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            START: begin
                if (tick) begin
                    state_d   = ADDR;
                    bit_cnt_d = 2'(SMB_ADDR_BITS - 1);
                end
            end
            ADDR: begin
                if (tick) begin
                    if (bit_cnt_q == 2'd0) state_d = DATA;
                    else bit_cnt_d = bit_cnt_q - 2'd1;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt_q == 2'(WIDTH - 1)) begin
                        state_d   = STOP;
                        bit_cnt_d = 2'd0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 2'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    mask_d = remaining;
                    if (remaining != '0) begin
                        state_d = START;
                        lane_d  = lowest_lane(remaining);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they line up with it once registered.
        serout_d = SMB_STOP_BIT;
        case (state_d)
            START:   serout_d = SMB_START_BIT;
            ADDR:    serout_d = lane_d[bit_cnt_d[0]];
            DATA:    serout_d = data_d[lane_d][bit_cnt_d];
            default: serout_d = SMB_STOP_BIT;
        endcase
        ready_d = (state_d == IDLE);
        busy_d  = (state_d == START) || (state_d == ADDR) ||
                  (state_d == DATA)  || (state_d == STOP);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            lane_q    <= 2'd0;
            bit_cnt_q <= 2'd0;
            data_q    <= '{default: '0};
            serout_q  <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            lane_q    <= lane_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            serout_q  <= serout_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.serout = serout_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_smb_serial_tx.sv
// Bench for smb_serial_tx: two instances (1 and 3 cycles per bit) checked cycle by
// cycle against a frame-list model built from the protocol rules.
module tb_smb_serial_tx;
    import smb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_s [2];
    logic [3:0]  pb_s    [2];
    logic [15:0] pls_s   [2];
    int          assert_count = 0;
    int          fail_count   = 0;

    smb_serial_tx_if #(.WIDTH(4)) bus0 ();
    smb_serial_tx_if #(.WIDTH(4)) bus1 ();

    // Lane i of a 16-bit word lives in bits [4i+3:4i]; its leftmost digit is sent first.
    assign bus0.valid = valid_s[0];
    assign bus0.PB    = pb_s[0];
    assign bus0.PL0   = pls_s[0][3:0];
    assign bus0.PL1   = pls_s[0][7:4];
    assign bus0.PL2   = pls_s[0][11:8];
    assign bus0.PL3   = pls_s[0][15:12];
    assign bus1.valid = valid_s[1];
    assign bus1.PB    = pb_s[1];
    assign bus1.PL0   = pls_s[1][3:0];
    assign bus1.PL1   = pls_s[1][7:4];
    assign bus1.PL2   = pls_s[1][11:8];
    assign bus1.PL3   = pls_s[1][15:12];

    smb_serial_tx #(.WIDTH(4), .BIT_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
    smb_serial_tx #(.WIDTH(4), .BIT_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

    always #5 clk = ~clk;

    function automatic logic [3:0] observe(input int d);
        if (d == 0) return {bus0.serout, bus0.busy, bus0.ready, bus0.done};
        return {bus1.serout, bus1.busy, bus1.ready, bus1.done};
    endfunction

    function automatic int bit_cycles(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        assert_count++;
        if (got !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkPins(input int d, input string tag, input logic ser,
                             input logic bsy, input logic rdy, input logic dn);
        logic [3:0] o;
        o = observe(d);
        checkOutput({tag, " serout"}, 32'(o[3]), 32'(ser));
        checkOutput({tag, " busy"},   32'(o[2]), 32'(bsy));
        checkOutput({tag, " ready"},  32'(o[1]), 32'(rdy));
        checkOutput({tag, " done"},   32'(o[0]), 32'(dn));
    endtask

    // Called at a falling edge with the DUT idle; returns at the falling edge of its first ready cycle.
    task automatic applyStimulus(input int d, input logic [3:0] pb, input logic [15:0] pls,
                                 input bit hold_valid);
        bit exp_bits[$];
        bit frame[SMB_FRAME_BITS];
        int bc = bit_cycles(d);
        for (int i = 0; i < SMB_LANES; i++) begin
            if (pb[i]) begin
                frame[0] = SMB_START_BIT;
                frame[1] = i[1];
                frame[2] = i[0];
                for (int j = 0; j < 4; j++) frame[3 + j] = pls[4 * i + 3 - j];
                frame[7] = SMB_STOP_BIT;
                for (int b = 0; b < SMB_FRAME_BITS; b++)
                    for (int r = 0; r < bc; r++) exp_bits.push_back(frame[b]);
            end
        end
        valid_s[d] = 1'b1;
        pb_s[d]    = pb;
        pls_s[d]   = pls;
        @(negedge clk);
        if (!hold_valid) valid_s[d] = 1'b0;
        for (int c = 0; c < exp_bits.size(); c++) begin
            checkPins(d, $sformatf("dut%0d pb%b c%0d", d, pb, c + 1), exp_bits[c], 1'b1, 1'b0, 1'b0);
            if (hold_valid) begin
                pb_s[d] = 4'hF;
                if (c == 1) pls_s[d][3:0] = ~pls_s[d][3:0];
            end else begin
                pb_s[d]  = 4'($urandom);
                pls_s[d] = 16'($urandom);
            end
            @(negedge clk);
        end
        checkPins(d, $sformatf("dut%0d pb%b donecyc", d, pb), 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        checkPins(d, $sformatf("dut%0d pb%b readycyc", d, pb), 1'b1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic resetMidFrame(input int d);
        int bc = bit_cycles(d);
        valid_s[d] = 1'b1;
        pb_s[d]    = 4'b0011;
        pls_s[d]   = 16'($urandom);
        @(negedge clk);
        valid_s[d] = 1'b0;
        repeat (4 * bc) @(negedge clk);
        checkOutput($sformatf("dut%0d busy before reset", d), 32'(observe(d)[2]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        checkPins(d, $sformatf("dut%0d after reset", d), 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        repeat (16 * bc + 4) begin
            @(negedge clk);
            checkPins(d, $sformatf("dut%0d idle post reset", d), 1'b1, 1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            valid_s[d] = 1'b0;
            pb_s[d]    = 4'b0;
            pls_s[d]   = 16'b0;
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) checkPins(d, $sformatf("dut%0d in reset", d), 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) checkPins(d, $sformatf("dut%0d idle", d), 1'b1, 1'b0, 1'b1, 1'b0);

        applyStimulus(0, 4'b0001, 16'h000A, 1'b0);
        applyStimulus(0, 4'b1010, {4'b0001, 4'b0000, 4'b1100, 4'b0000}, 1'b0);
        applyStimulus(0, 4'b0000, 16'($urandom), 1'b0);
        applyStimulus(1, 4'b0100, 16'h0600, 1'b0);
        applyStimulus(1, 4'b0000, 16'($urandom), 1'b0);

        for (int d = 0; d < 2; d++) begin
            applyStimulus(d, 4'b0101, 16'($urandom), 1'b1);
            applyStimulus(d, pb_s[d], pls_s[d], 1'b0);
        end

        resetMidFrame(0);
        resetMidFrame(1);

        for (int n = 0; n < 24; n++) begin
            int          d;
            logic [3:0]  pb;
            bit          hold;
            d    = n % 2;
            pb   = (n % 5 == 0) ? 4'b0000 : 4'($urandom);
            hold = (n % 7 == 3);
            applyStimulus(d, pb, 16'($urandom), hold);
            if (hold) applyStimulus(d, pb_s[d], pls_s[d], 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/smb_serial_tx.md
# smb_serial_tx

Serial multi-broadcast transmitter: the sending end of the SMB serial lane protocol. It captures up to four parallel 4-bit lane words and a lane mask in one handshake, then serializes one framed word per selected lane onto a single serial line, in ascending lane order. It sits upstream of the SMB receiver/broadcaster, which rebuilds the lane words from the frames.

## Interface
- WIDTH, 4, data bits per lane word; the frame layout below is fixed for 4.
- BIT_CYCLES, 1, clock cycles each serial bit is held; legal range 1..255.

- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- valid  in  1  request; a transfer is accepted on a cycle where valid && ready
- PB  in  4  lane mask; bit i set sends lane i
- PL0..PL3  in  [0:WIDTH-1] each  lane words; bit index 0 is transmitted first
- ready  out  1  high only in IDLE
- busy  out  1  high from the cycle after acceptance until the done cycle, exclusive
- done  out  1  one-cycle pulse at the end of each accepted transfer
- serout  out  1  serial line; idles high

## Operation
- Frame format, 8 bits: start bit 0; lane index, 2 bits, MSB first; data bits PLi[0]..PLi[3]; stop bit 1.
- Acceptance:
  - Registers PB and all four lane words.
  - Later input changes have no effect until the next acceptance.
- FSM states: IDLE, START, ADDR, DATA, STOP, DONE.
- IDLE:
  - ready=1, serout=1.
  - On acceptance with PB!=0, go to START with the lowest set lane selected.
  - On acceptance with PB==0, go to DONE.
- START, then ADDR (bit counter 1..0), then DATA (counter 0..3), then STOP.
- Each bit is held BIT_CYCLES cycles, timed by a bit-tick counter.
- After STOP:
  - The selected lane's mask bit is cleared.
  - If mask bits remain, go to START on the next lowest lane. There is no idle gap between frames.
  - Otherwise go to DONE.
- DONE: done=1, serout=1 for one cycle, then IDLE.
- valid while ready=0 is ignored and not queued.

## Timing
- Reset values: serout=1, ready=1, busy=0, done=0, state IDLE, mask=0, counters=0.
- Reset asserted mid-frame aborts the frame. On the next cycle serout=1 and ready=1, and done is not pulsed.
- Acceptance at edge k:
  - The start bit appears on serout in cycle k+1.
  - ready and busy change in cycle k+1.
- One frame lasts 8*BIT_CYCLES cycles.
- With N lanes selected:
  - serout carries 8*N*BIT_CYCLES contiguous bit-cycles.
  - done is asserted in the cycle immediately after the last stop bit.
  - ready=1 from the cycle after done.
- PB==0: done in cycle k+1, ready=1 in cycle k+2, serout stays 1.
- serout is a registered output. It has no combinational path from any input.

## Structure
- Package smb_pkg holds:
  - the state enum smb_tx_state_t;
  - constants SMB_START_BIT=0, SMB_STOP_BIT=1, SMB_ADDR_BITS=2, SMB_FRAME_BITS=8, SMB_LANES=4.
- The SMB receiver imports the same package.
- Sub-module smb_bit_timer: a BIT_CYCLES divider with a restart input and a one-cycle tick output. It is restarted at every bit boundary and on acceptance.
- Lane selection is a priority encoder on the remaining mask. Keep it inline in smb_serial_tx.

## Test plan
- Single lane:
  - Stimulus: PB=0001, PL0=1010, BIT_CYCLES=1.
  - Response: serout = 0,0,0,1,0,1,0,1 over cycles k+1..k+8; done in k+9; ready in k+10.
- Two lanes:
  - Stimulus: PB=1010, PL1=1100, PL3=0001.
  - Response: frames 0,01,1100,1 then 0,11,0001,1 back-to-back with no gap; done once, after 16 bit-cycles.
- Empty mask:
  - Stimulus: PB=0000, valid for one cycle.
  - Response: done in k+1, serout constantly 1, busy never asserted.
- Bit stretching:
  - Stimulus: BIT_CYCLES=3, PB=0100, PL2=0110.
  - Response: every bit held exactly 3 cycles (24 cycles total); lane index 10 sent MSB first.
- Ignored requests:
  - Stimulus: valid held high with PB=1111 during a transfer, plus PL0 changed mid-frame.
  - Response: no restart; captured PL0 data is transmitted; a second transfer starts only on the cycle where ready=1.
- Reset mid-frame:
  - Stimulus: rst asserted during DATA of lane 0 (PB=0011).
  - Response: serout=1, ready=1 on the next cycle; no done pulse; lane 1 is never sent.
